// File: rtl/fifo_pkg.sv
// Shared definitions for sync_fifo_param: pointer/level width, parameter legality and reset values.
package fifo_pkg;

    localparam int unsigned MinAddrWidth = 2;

    localparam logic RstRvld = 1'b0;
    localparam logic RstOvf  = 1'b0;
    localparam logic RstUdf  = 1'b0;

    // Pointers and level carry one extra bit so that a full FIFO is distinguishable from empty.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit params_legal(input int unsigned addr_width,
                                        input int unsigned afull_thr,
                                        input int unsigned aempt_thr);
        return (addr_width >= MinAddrWidth) && (aempt_thr > 0) &&
               (aempt_thr < afull_thr) && (afull_thr < (32'd1 << addr_width));
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a producer/consumer (master) and sync_fifo_param (slave).
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4
);
    logic                                 iWINC;
    logic [DATAWIDTH-1:0]                 iWDAT;
    logic                                 oFULL;
    logic                                 oAFULL;
    logic                                 iRINC;
    logic [DATAWIDTH-1:0]                 oRDAT;
    logic                                 oRVLD;
    logic                                 oEMPT;
    logic                                 oAEMPT;
    logic [ptr_width(ADDRWIDTH)-1:0]      oLEVEL;
    logic                                 oOVF;
    logic                                 oUDF;

    modport master (
        output iWINC, iWDAT, iRINC,
        input  oFULL, oAFULL, oRDAT, oRVLD, oEMPT, oAEMPT, oLEVEL, oOVF, oUDF
    );

    modport slave (
        input  iWINC, iWDAT, iRINC,
        output oFULL, oAFULL, oRDAT, oRVLD, oEMPT, oAEMPT, oLEVEL, oOVF, oUDF
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDRWIDTH-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [ADDRWIDTH-1:0] raddr_i,
    output logic [DATAWIDTH-1:0] rdata_o
);
    localparam int unsigned Depth = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level, thresholds and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned AFULL_THR = 12,
    parameter int unsigned AEMPT_THR = 2
) (
    input logic               iCLK,
    input logic               iRST,
    sync_fifo_param_if.slave  fifo
);
    localparam int unsigned PtrW  = ptr_width(ADDRWIDTH);
    localparam int unsigned Depth = 1 << ADDRWIDTH;

    if (!params_legal(ADDRWIDTH, AFULL_THR, AEMPT_THR)) begin : gen_bad_params
        $fatal(1, "sync_fifo_param: illegal ADDRWIDTH/AFULL_THR/AEMPT_THR combination");
    end

    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic                 full, empty, wr_en, rd_en;
    logic [DATAWIDTH-1:0] ram_rdata;

    assign full  = (level_q == PtrW'(Depth));
    assign empty = (level_q == '0);
    assign wr_en = fifo.iWINC && !full;
    assign rd_en = fifo.iRINC && !empty;

    fifo_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .clk_i   (iCLK),
        .we_i    (wr_en),
        .waddr_i (wptr_q[ADDRWIDTH-1:0]),
        .wdata_i (fifo.iWDAT),
        .raddr_i (rptr_q[ADDRWIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ovf_d = fifo.iWINC && full;
        udf_d = fifo.iRINC && empty;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= RstOvf;
            udf_q   <= RstUdf;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through straight from the array; iRINC only pops.
    assign fifo.oRDAT = ram_rdata;
    assign fifo.oRVLD = !empty;
`else
    logic [DATAWIDTH-1:0] rdat_q, rdat_d;
    logic                 rvld_q, rvld_d;

    always_comb begin
        rdat_d = rd_en ? ram_rdata : rdat_q;
        rvld_d = rd_en;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rdat_q <= '0;
            rvld_q <= RstRvld;
        end else begin
            rdat_q <= rdat_d;
            rvld_q <= rvld_d;
        end
    end

    assign fifo.oRDAT = rdat_q;
    assign fifo.oRVLD = rvld_q;
`endif

    assign fifo.oFULL  = full;
    assign fifo.oEMPT  = empty;
    assign fifo.oAFULL = (level_q >= PtrW'(AFULL_THR));
    assign fifo.oAEMPT = (level_q <= PtrW'(AEMPT_THR));
    assign fifo.oLEVEL = level_q;
    assign fifo.oOVF   = ovf_q;
    assign fifo.oUDF   = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (default 8x16, thresholds 12/2).
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus ();

    sync_fifo_param #(
        .DATAWIDTH (8),
        .ADDRWIDTH (4),
        .AFULL_THR (12),
        .AEMPT_THR (2)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .fifo (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iWINC = 1'b0;
        bus.iRINC = 1'b0;
        bus.iWDAT = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.oEMPT !== 1'b1) begin n_err++; $display("FAIL reset_empt got %b want 1", bus.oEMPT); end
        n_cmp++; if (bus.oAEMPT !== 1'b1) begin n_err++; $display("FAIL reset_aempt got %b want 1", bus.oAEMPT); end
        n_cmp++; if (bus.oLEVEL !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", bus.oLEVEL); end
        n_cmp++; if (bus.oFULL !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.oFULL); end
        n_cmp++; if (bus.oAFULL !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", bus.oAFULL); end
        n_cmp++; if (bus.oRVLD !== 1'b0) begin n_err++; $display("FAIL reset_rvld got %b want 0", bus.oRVLD); end
        n_cmp++; if ({bus.oOVF, bus.oUDF} !== 2'b00) begin n_err++; $display("FAIL reset_ovf_udf got %b want 00", {bus.oOVF, bus.oUDF}); end
`ifndef FIFO_FWFT_EN
        n_cmp++; if (bus.oRDAT !== 8'h00) begin n_err++; $display("FAIL reset_rdat got %h want 00", bus.oRDAT); end
`endif
    endtask

    task automatic fill16();
        for (int i = 1; i <= 16; i++) begin
            bus.iWINC = 1'b1;
            bus.iWDAT = 8'(i);
            tick();
        end
        idle();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            bus.iWINC = 1'b1;
            bus.iWDAT = 8'(i);
            tick();
            n_cmp++; if (bus.oLEVEL !== 5'(i)) begin n_err++; $display("FAIL fill_level[%0d] got %0d want %0d", i, bus.oLEVEL, i); end
            n_cmp++; if ({bus.oFULL, bus.oAFULL, bus.oAEMPT, bus.oEMPT} !== {i == 16, i >= 12, i <= 2, 1'b0})
                begin n_err++; $display("FAIL fill_flags[%0d] got %b want %b", i, {bus.oFULL, bus.oAFULL, bus.oAEMPT, bus.oEMPT}, {i == 16, i >= 12, i <= 2, 1'b0}); end
        end
        bus.iWDAT = 8'hEE;
        tick();
        n_cmp++; if (bus.oOVF !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b want 1", bus.oOVF); end
        n_cmp++; if (bus.oLEVEL !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d want 16", bus.oLEVEL); end
        idle();
        tick();
        n_cmp++; if (bus.oOVF !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle got %b want 0", bus.oOVF); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            bus.iRINC = 1'b1;
`ifdef FIFO_FWFT_EN
            n_cmp++; if (bus.oRDAT !== 8'(i) || bus.oRVLD !== 1'b1) begin n_err++; $display("FAIL drain_data[%0d] got %h/%b want %h/1", i, bus.oRDAT, bus.oRVLD, 8'(i)); end
            tick();
`else
            tick();
            n_cmp++; if (bus.oRDAT !== 8'(i) || bus.oRVLD !== 1'b1) begin n_err++; $display("FAIL drain_data[%0d] got %h/%b want %h/1", i, bus.oRDAT, bus.oRVLD, 8'(i)); end
`endif
            n_cmp++; if ({bus.oLEVEL, bus.oAEMPT, bus.oEMPT} !== {5'(16 - i), (16 - i) <= 2, i == 16})
                begin n_err++; $display("FAIL drain_state[%0d] got %b want %b", i, {bus.oLEVEL, bus.oAEMPT, bus.oEMPT}, {5'(16 - i), (16 - i) <= 2, i == 16}); end
        end
        tick();
        n_cmp++; if (bus.oUDF !== 1'b1 || bus.oRVLD !== 1'b0) begin n_err++; $display("FAIL udf_pulse got %b/%b want 1/0", bus.oUDF, bus.oRVLD); end
        idle();
        tick();
        n_cmp++; if (bus.oUDF !== 1'b0 || bus.oLEVEL !== 5'd0) begin n_err++; $display("FAIL udf_one_cycle got %b/%0d want 0/0", bus.oUDF, bus.oLEVEL); end
`ifndef FIFO_FWFT_EN
        n_cmp++; if (bus.oRDAT !== 8'h10) begin n_err++; $display("FAIL rdat_hold got %h want 10", bus.oRDAT); end
`endif
    endtask

    task automatic test_full_both();
        fill16();
        bus.iWINC = 1'b1;
        bus.iRINC = 1'b1;
        bus.iWDAT = 8'h77;
`ifdef FIFO_FWFT_EN
        n_cmp++; if (bus.oRDAT !== 8'h01) begin n_err++; $display("FAIL full_both_head got %h want 01", bus.oRDAT); end
        tick();
`else
        tick();
        n_cmp++; if (bus.oRDAT !== 8'h01 || bus.oRVLD !== 1'b1) begin n_err++; $display("FAIL full_both_head got %h/%b want 01/1", bus.oRDAT, bus.oRVLD); end
`endif
        n_cmp++; if (bus.oLEVEL !== 5'd15 || bus.oOVF !== 1'b1) begin n_err++; $display("FAIL full_both_state got %0d/%b want 15/1", bus.oLEVEL, bus.oOVF); end
        idle();
        // Rejected 0x77 must not appear: remaining words are 0x02..0x10.
        for (int i = 2; i <= 16; i++) begin
            bus.iRINC = 1'b1;
`ifdef FIFO_FWFT_EN
            n_cmp++; if (bus.oRDAT !== 8'(i)) begin n_err++; $display("FAIL full_both_rest[%0d] got %h want %h", i, bus.oRDAT, 8'(i)); end
            tick();
`else
            tick();
            n_cmp++; if (bus.oRDAT !== 8'(i)) begin n_err++; $display("FAIL full_both_rest[%0d] got %h want %h", i, bus.oRDAT, 8'(i)); end
`endif
        end
        idle();
        n_cmp++; if (bus.oEMPT !== 1'b1) begin n_err++; $display("FAIL full_both_empty got %b want 1", bus.oEMPT); end
    endtask

    task automatic test_empty_both();
        bus.iWINC = 1'b1;
        bus.iRINC = 1'b1;
        bus.iWDAT = 8'h55;
        tick();
        n_cmp++; if (bus.oLEVEL !== 5'd1 || bus.oUDF !== 1'b1) begin n_err++; $display("FAIL empty_both_state got %0d/%b want 1/1", bus.oLEVEL, bus.oUDF); end
`ifndef FIFO_FWFT_EN
        n_cmp++; if (bus.oRVLD !== 1'b0) begin n_err++; $display("FAIL empty_both_rvld got %b want 0", bus.oRVLD); end
`endif
        bus.iWINC = 1'b0;
`ifdef FIFO_FWFT_EN
        n_cmp++; if (bus.oRDAT !== 8'h55) begin n_err++; $display("FAIL empty_both_data got %h want 55", bus.oRDAT); end
        tick();
`else
        tick();
        n_cmp++; if (bus.oRDAT !== 8'h55) begin n_err++; $display("FAIL empty_both_data got %h want 55", bus.oRDAT); end
`endif
        idle();
        n_cmp++; if (bus.oLEVEL !== 5'd0) begin n_err++; $display("FAIL empty_both_level got %0d want 0", bus.oLEVEL); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            bus.iWINC = 1'b1;
            bus.iWDAT = 8'(i);
            tick();
        end
        for (int c = 0; c < 40; c++) begin
            bus.iWINC = 1'b1;
            bus.iRINC = 1'b1;
            bus.iWDAT = 8'(c + 8);
`ifdef FIFO_FWFT_EN
            n_cmp++; if (bus.oRDAT !== 8'(c)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", c, bus.oRDAT, 8'(c)); end
            tick();
`else
            tick();
            n_cmp++; if (bus.oRDAT !== 8'(c)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", c, bus.oRDAT, 8'(c)); end
`endif
            n_cmp++; if (bus.oLEVEL !== 5'd8) begin n_err++; $display("FAIL wrap_level[%0d] got %0d want 8", c, bus.oLEVEL); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        // Level is 8 from the wrap test; one more write reaches 9.
        bus.iWINC = 1'b1;
        bus.iWDAT = 8'h3C;
        tick();
        n_cmp++; if (bus.oLEVEL !== 5'd9) begin n_err++; $display("FAIL pre_reset_level got %0d want 9", bus.oLEVEL); end
        rst = 1'b1;
        bus.iRINC = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_cmp++; if (bus.oLEVEL !== 5'd0 || bus.oEMPT !== 1'b1) begin n_err++; $display("FAIL mid_reset_state got %0d/%b want 0/1", bus.oLEVEL, bus.oEMPT); end
        n_cmp++; if (bus.oRVLD !== 1'b0) begin n_err++; $display("FAIL mid_reset_rvld got %b want 0", bus.oRVLD); end
        bus.iWINC = 1'b1;
        bus.iWDAT = 8'hA5;
        tick();
        idle();
`ifdef FIFO_FWFT_EN
        n_cmp++; if (bus.oRDAT !== 8'hA5 || bus.oRVLD !== 1'b1) begin n_err++; $display("FAIL post_reset_fwft got %h/%b want a5/1", bus.oRDAT, bus.oRVLD); end
        bus.iRINC = 1'b1;
        tick();
`else
        bus.iRINC = 1'b1;
        tick();
        n_cmp++; if (bus.oRDAT !== 8'hA5 || bus.oRVLD !== 1'b1) begin n_err++; $display("FAIL post_reset_read got %h/%b want a5/1", bus.oRDAT, bus.oRVLD); end
`endif
        idle();
        n_cmp++; if (bus.oEMPT !== 1'b1) begin n_err++; $display("FAIL post_reset_empty got %b want 1", bus.oEMPT); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_full_both();
        test_empty_both();
        test_wrap();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for buffering sample streams between pipeline stages of the configurable FIR datapath (e.g. coefficient loader to MAC array, filter output to host interface). It is the next generation of our dual-pointer FIFO. Width and depth are generic, with an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses and an optional first-word-fall-through read mode.

## Interface
- DATAWIDTH, 8, data word width in bits
- ADDRWIDTH, 4, log2 of depth; DEPTH = 2**ADDRWIDTH (default 16)
- AFULL_THR, 12, oAFULL asserted when level >= AFULL_THR
- AEMPT_THR, 2, oAEMPT asserted when level <= AEMPT_THR
- Legal range: 0 < AEMPT_THR < AFULL_THR < DEPTH; ADDRWIDTH >= 2

- iCLK  in  1  single clock, all state on rising edge
- iRST  in  1  reset; one clock; reset is synchronous and active-high
- iWINC  in  1  write request
- iWDAT  in  DATAWIDTH  write data
- oFULL  out  1  level == DEPTH
- oAFULL  out  1  level >= AFULL_THR
- iRINC  in  1  read request
- oRDAT  out  DATAWIDTH  read data
- oRVLD  out  1  oRDAT valid
- oEMPT  out  1  level == 0
- oAEMPT  out  1  level <= AEMPT_THR
- oLEVEL  out  ADDRWIDTH+1  current occupancy, 0..DEPTH
- oOVF  out  1  one-cycle pulse: write requested while full
- oUDF  out  1  one-cycle pulse: read requested while empty

## Operation
- Write accepted iff iWINC && !oFULL; word stored at wAddr, wAddr increments modulo DEPTH.
- Read accepted iff iRINC && !oEMPT; rAddr increments modulo DEPTH.
- Pointers are ADDRWIDTH+1 bits binary; the MSB distinguishes wrap. Level register tracks occupancy: +1 on write only, -1 on read only, unchanged on both or neither.
- All status flags are decoded combinationally from the registered level; no other combinational path from inputs to flags.
- Simultaneous read+write when full: read accepted, write rejected, oOVF pulses; level goes DEPTH-1.
- Simultaneous read+write when empty: write accepted, read rejected, oUDF pulses; level goes 1.
- Rejected accesses change no state other than oOVF/oUDF.
- Memory contents are not reset; all other state is reset.
- Reset values: oFULL=0, oAFULL=0, oEMPT=1, oAEMPT=1, oLEVEL=0, oRDAT=0, oRVLD=0, oOVF=0, oUDF=0. Pointers are 0.
- Reset mid-operation discards all stored words. Inputs in the reset cycle are ignored.

## Timing
- Write at edge N: oLEVEL/oEMPT update after edge N; the word is readable from edge N+1.
- Standard read: read accepted at edge N gives oRDAT registered after edge N and oRVLD=1 for that one cycle. oRDAT holds its value until the next accepted read.
- Throughput is one write and one read per cycle sustained. Full-to-not-full and empty-to-not-empty each take one cycle.
- oOVF/oUDF are registered: they assert after the offending edge for exactly one cycle.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through.
  - oRDAT = head word combinationally from memory whenever !oEMPT; oRVLD = !oEMPT.
  - iRINC acts as pop/acknowledge, and the next word appears after the edge.
  - Zero read latency.
  - oRDAT is don't-care while empty.
- FIFO_FWFT_EN undefined: standard registered read as in Timing, with one-cycle latency.

## Structure
- Shared package fifo_pkg holds:
  - the pointer/level width derivation (ADDRWIDTH+1)
  - the parameter legality check constants
  - the reset constants for flags
- Sub-module fifo_ram: simple dual-port array, DEPTH x DATAWIDTH, synchronous write, asynchronous read, no reset. The top module holds the pointers, level, flags and read register.

## Test plan
- Reset then idle: oEMPT=1, oAEMPT=1, oLEVEL=0, oRVLD=0, oFULL=0.
- Write 16 words 0x01..0x10 back-to-back (defaults): oAFULL asserts after the 12th write, oFULL after the 16th, oLEVEL=16. A 17th write gives oOVF pulse and oLEVEL stays 16.
- Read all 16: data 0x01..0x10 in order, oRVLD each cycle. oAEMPT asserts at level 2, oEMPT after the last read. An extra read gives oUDF pulse.
- Full FIFO with iWINC=iRINC=1 for 1 cycle: oLEVEL=15, oOVF=1, head 0x01 read. Empty FIFO with both high: oLEVEL=1, oUDF=1.
- Wrap-around: 40 cycles of simultaneous read/write at level 8 with an incrementing pattern. Level stays 8, the output sequence lags the input by 8, and there is no corruption across pointer wrap.
- iRST asserted at level 9: next cycle oLEVEL=0, oEMPT=1. A subsequent write/read of 0xA5 returns 0xA5. Repeat with FIFO_FWFT_EN defined: 0xA5 is visible on oRDAT the cycle after the write, with no iRINC.
